// File: rtl/ir_prefetch_queue.sv
// Prefetch FIFO of DEPTH instruction words feeding an instruction register.
// Optional same-cycle empty bypass into the IR is enabled by defining IR_PREFETCH_BYPASS_EN.
module ir_prefetch_queue #(
  parameter int IR_width     = 12,
  parameter int DEPTH        = 4,
  parameter int OPCODE_width = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            write_en,
  input  logic [IR_width-1:0]             bus_data,
  input  logic                            load_ir,
  input  logic                            flush,
  output logic [IR_width-1:0]             dataout,
  output logic [OPCODE_width-1:0]         opcode,
  output logic [IR_width-OPCODE_width-1:0] operand,
  output logic                            ir_valid,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic                            overflow
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = $clog2(DEPTH+1);
  localparam int OPERAND_W = IR_width - OPCODE_width;

  logic [IR_width-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [IR_width-1:0] dataout_q, dataout_d;
  logic                ir_valid_q, ir_valid_d;
  logic                overflow_q, overflow_d;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;
  logic bypass_s;

  // Next-state logic: flush wins, then push/pop/bypass arbitration.
  always_comb begin
    full_s     = (count_q == CNT_W'(DEPTH));
    empty_s    = (count_q == {CNT_W{1'b0}});
    push_s     = 1'b0;
    pop_s      = 1'b0;
    bypass_s   = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dataout_d  = dataout_q;
    ir_valid_d = ir_valid_q;
    overflow_d = overflow_q;

    if (flush) begin
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      count_d    = {CNT_W{1'b0}};
      ir_valid_d = 1'b0;
    end else begin
`ifdef IR_PREFETCH_BYPASS_EN
      bypass_s = empty_s && write_en && load_ir;
`else
      bypass_s = 1'b0;
`endif
      pop_s  = load_ir && !empty_s;
      // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
      push_s = write_en && (!full_s || pop_s) && !bypass_s;

      if (bypass_s) begin
        dataout_d  = bus_data;
        ir_valid_d = 1'b1;
      end else if (pop_s) begin
        dataout_d  = mem_q[rd_ptr_q];
        ir_valid_d = 1'b1;
      end else if (load_ir) begin
        ir_valid_d = 1'b0;
      end else begin
        ir_valid_d = ir_valid_q;
      end

      if (write_en && full_s && !pop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end

      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and IR state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      dataout_q  <= {IR_width{1'b0}};
      ir_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dataout_q  <= dataout_d;
      ir_valid_q <= ir_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus_data;
    end
  end

  assign dataout  = dataout_q;
  assign opcode   = dataout_q[IR_width-1 -: OPCODE_width];
  assign operand  = dataout_q[OPERAND_W-1:0];
  assign ir_valid = ir_valid_q;
  assign full     = full_s;
  assign empty    = empty_s;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
